// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
//   Shared types for the round-robin APB requester port.
//   - apb_state_e : bus phase of the shared APB master (IDLE/SETUP/ACCESS)
//   - APB_NOP/READ/WRITE : command encoding of the transfer currently on the bus
//   - apb_cmd()   : folds "bus active" and the direction bit into a command code
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [1:0] APB_NOP   = 2'd0;
  localparam logic [1:0] APB_READ  = 2'd1;
  localparam logic [1:0] APB_WRITE = 2'd2;

  // Command currently presented on the bus; NOP when no transfer is in flight.
  function automatic logic [1:0] apb_cmd(input logic active, input logic write);
    if (!active)   return APB_NOP;
    else if (write) return APB_WRITE;
    else            return APB_READ;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin request picker. The search starts at the rotating pointer and
//   wraps modulo NUM_REQ; the first set request bit wins. The pointer moves to
//   winner+1 only when the caller accepts the grant (grant_en_i).
// Ports
//   pclk, preset_n : clock, async active-low reset (pointer -> 0)
//   req_i          : request vector
//   grant_en_i     : caller takes the current grant this cycle
//   grant_o        : one-hot winner (combinational)
//   grant_idx_o    : winner index (combinational)
//   grant_vld_o    : at least one request is pending
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               grant_vld_o
);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   cand;

  // Walk NUM_REQ slots starting at ptr_q; the extra bit in cand absorbs the
  // carry before the modulo wrap.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_vld_o && req_i[cand[IW-1:0]]) begin
        grant_vld_o              = 1'b1;
        grant_idx_o              = cand[IW-1:0];
        grant_o[cand[IW-1:0]]    = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ptr_q <= '0;
    end else if (grant_en_i && grant_vld_o) begin
      ptr_q <= (grant_idx_o == IW'(NUM_REQ-1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
//   Shares one APB3 requester port among NUM_REQ local requesters. A
//   round-robin winner is picked in IDLE, its command is latched onto the bus
//   and walked through SETUP and ACCESS. ACCESS ends on pready_i or after
//   TIMEOUT cycles without it (forced completion with err_o).
// Ports
//   pclk, preset_n           : clock, async active-low reset
//   req_i / req_write_i      : per-requester request and direction
//   req_addr_i / req_wdata_i : packed per-requester address / write data
//   done_o                   : one-hot completion strobe (combinational, ACCESS only)
//   rdata_o                  : read data during a read completion, else 0
//   err_o                    : completion was forced by timeout
//   psel_o .. pwdata_o       : APB master outputs (registered)
//   prdata_i, pready_i       : APB slave responses
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e          state_q;
  logic [NUM_REQ-1:0]  owner_q;    // one-hot owner of the transfer in flight
  logic [CW-1:0]       to_cnt_q;   // ACCESS cycles spent without pready_i

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic                timeout;
  logic                complete;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .req_i       (req_i),
    .grant_en_i  (state_q == ST_IDLE),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign timeout  = (to_cnt_q == CW'(TIMEOUT-1));
  assign complete = (state_q == ST_ACCESS) && (pready_i || timeout);

  // Completion is decoded combinationally so the requester sees it in the
  // same cycle the slave answers; pready wins over a coincident timeout.
  assign done_o  = complete ? owner_q : '0;
  assign err_o   = complete && !pready_i;
  assign rdata_o = (complete && apb_cmd(1'b1, pwrite_o) == APB_READ) ? prdata_i : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      owner_q   <= '0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Winner's command is captured here; later req_* changes are ignored.
          if (grant_vld) begin
            state_q  <= ST_SETUP;
            psel_o   <= 1'b1;
            paddr_o  <= req_addr_i[grant_idx*ADDR_W +: ADDR_W];
            pwrite_o <= req_write_i[grant_idx];
            pwdata_o <= req_wdata_i[grant_idx*DATA_W +: DATA_W];
            owner_q  <= grant;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_o <= 1'b1;
          to_cnt_q  <= '0;
        end
        ST_ACCESS: begin
          if (complete) begin
            state_q   <= ST_IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end else begin
            to_cnt_q  <= to_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all continuously compared against a transaction-level
// model (busy flag, age since grant, owner, rotating pointer).
module tb_apb_rr_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0] done_o;
  logic [DW-1:0] rdata_o;
  logic          err_o, psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  always #5 pclk = ~pclk;

  apb_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_i(req), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata), .pready_i(pready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit            m_busy;
  int            m_age;    // edges since grant: 1 = setup, 2.. = access
  int            m_owner;
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;

  function automatic bit m_done_now();
    return m_busy && (m_age >= 2) && (pready || (m_age - 1 == TO));
  endfunction

  always @(posedge pclk or negedge preset_n) begin : model
    if (!preset_n) begin
      m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 0;
      m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    end else if (m_busy) begin
      if (m_done_now()) m_busy = 0;
      else m_age++;
    end else if (req != '0) begin
      m_owner = -1;
      for (int k = 0; k < NR; k++)
        if (m_owner < 0 && req[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
      m_ptr   = (m_owner + 1) % NR;
      m_busy  = 1;
      m_age   = 1;
      m_addr  = req_addr[m_owner*AW +: AW];
      m_wr    = req_write[m_owner];
      m_wdata = req_wdata[m_owner*DW +: DW];
    end
  end

  always @(negedge pclk) begin : compare
    logic [NR-1:0] e_done;
    bit            cmpl;
    if (cmp_en) begin
      cmpl   = m_done_now();
      e_done = cmpl ? (NR'(1) << m_owner) : '0;
      chk("psel",    psel_o,    m_busy);
      chk("penable", penable_o, m_busy && m_age >= 2);
      chk("paddr",   paddr_o,   m_addr);
      chk("pwrite",  pwrite_o,  m_wr);
      chk("pwdata",  pwdata_o,  m_wdata);
      chk("done",    done_o,    e_done);
      chk("err",     err_o,     cmpl && !pready);
      chk("rdata",   rdata_o,   (cmpl && !m_wr) ? prdata : '0);
    end
  end

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic rnd_fields(input int i);
    req_write[i] = 1'($urandom_range(1));
    req_addr[i*AW +: AW] = $urandom;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  initial begin : stim
    logic [NR-1:0] d;
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int cyc, last, n;
    bit seen;

    #1 preset_n = 1'b0;
    cmp_en = 1;
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;

    // T1: reset in the middle of a transfer
    @(posedge pclk); #1 set_req(2, 1'b1, 32'hAB0, 32'h55); pready = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      chk("t1_psel", psel_o, 0); chk("t1_penable", penable_o, 0);
      chk("t1_done", done_o, 0); chk("t1_err", err_o, 0); chk("t1_paddr", paddr_o, 0);
    end
    @(posedge pclk); #1 req = '0; preset_n = 1'b1;

    // T4: fairness with all requesters busy
    @(posedge pclk); #1 pready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'(i % 2), AW'(i*256 + 4), $urandom);
    cyc = 0; last = 0;
    while (order.size() < 6 && cyc < 60) begin
      @(negedge pclk); d = done_o; cyc++;
      if (d != '0) begin
        order.push_back(oh2idx(d));
        if (order.size() > 1) chk("t4_spacing", cyc - last, 3);
        last = cyc;
      end
      @(posedge pclk); #1 req = {NR{1'b1}} & ~d;
    end
    req = '0;
    chk("t4_count", order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++) chk("t4_order", order[k], exp_order[k]);

    // T2: single read with one wait state
    @(posedge pclk); #1 set_req(1, 1'b0, 32'h10, 32'h0); pready = 1'b0; prdata = 32'h1234_5678;
    @(posedge pclk);
    @(negedge pclk);
    chk("t2_psel", psel_o, 1); chk("t2_penable", penable_o, 0);
    chk("t2_paddr", paddr_o, 32'h10); chk("t2_pwrite", pwrite_o, 0);
    @(posedge pclk);
    @(negedge pclk);
    chk("t2_penable2", penable_o, 1); chk("t2_nodone", done_o, 0);
    @(posedge pclk); #1 pready = 1'b1;
    @(negedge pclk);
    chk("t2_done", done_o, 4'b0010); chk("t2_rdata", rdata_o, 32'h1234_5678); chk("t2_err", err_o, 0);
    @(posedge pclk); #1 req = '0; pready = 1'b0;
    @(negedge pclk);
    chk("t2_idle", psel_o, 0);

    // T3: write; changes after grant must not reach the bus
    @(posedge pclk); #1 set_req(2, 1'b1, 32'h24, 32'hDEAD_BEEF); pready = 1'b1; prdata = 32'hFFFF_FFFF;
    @(posedge pclk); #1 req_wdata[2*DW +: DW] = 32'h0BAD_F00D; req_addr[2*AW +: AW] = 32'h99; req_write[2] = 1'b0;
    @(negedge pclk);
    chk("t3_psel", psel_o, 1); chk("t3_pwrite", pwrite_o, 1);
    chk("t3_pwdata", pwdata_o, 32'hDEAD_BEEF); chk("t3_paddr", paddr_o, 32'h24);
    @(negedge pclk);
    chk("t3_penable", penable_o, 1); chk("t3_pwrite2", pwrite_o, 1);
    chk("t3_pwdata2", pwdata_o, 32'hDEAD_BEEF); chk("t3_done", done_o, 4'b0100);
    chk("t3_rdata", rdata_o, 0); chk("t3_err", err_o, 0);
    @(posedge pclk); #1 req = '0; pready = 1'b0;

    // T5: timeout
    @(posedge pclk); #1 set_req(0, 1'b0, 32'h50, 32'h0); pready = 1'b0;
    n = 0; seen = 0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge pclk);
      if (penable_o) n++;
      if (done_o != '0) begin
        seen = 1;
        chk("t5_done", done_o, 4'b0001); chk("t5_err", err_o, 1);
      end
    end
    chk("t5_done_seen", seen, 1);
    chk("t5_access_cycles", n, TO);
    @(posedge pclk); #1 req = '0;
    @(negedge pclk);
    chk("t5_psel_off", psel_o, 0);

    // T6: reset mid-ACCESS, then re-arbitration from pointer 0
    @(posedge pclk); #1 set_req(2, 1'b0, 32'h70, 32'h0); pready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge pclk);
      if (penable_o) seen = 1;
    end
    chk("t6_in_access", seen, 1);
    #2 preset_n = 1'b0;
    req = '0; set_req(0, 1'b0, 32'h80, 32'h0); set_req(3, 1'b0, 32'h84, 32'h0);
    #1;
    chk("t6_psel_async", psel_o, 0); chk("t6_penable_async", penable_o, 0); chk("t6_nodone", done_o, 0);
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b1; pready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge pclk);
      if (done_o != '0) begin
        seen = 1;
        chk("t6_first_grant", done_o, 4'b0001);
      end
    end
    chk("t6_done_seen", seen, 1);
    @(posedge pclk); #1 req = '0;

    // Randomized traffic, including stall windows that force timeouts
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk); d = done_o;
      @(posedge pclk); #1;
      for (int i = 0; i < NR; i++) begin
        if (d[i]) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin rnd_fields(i); req[i] = 1'b1; end
        end else begin
          if ($urandom_range(3) == 0) rnd_fields(i);
          if ($urandom_range(31) == 0) req[i] = 1'b0;
        end
      end
      pready = ((c % 400) < 60) ? 1'b0 : ($urandom_range(2) != 0);
      prdata = $urandom;
    end
    @(posedge pclk); #1 req = '0; pready = 1'b1;
    repeat (30) @(posedge pclk);
    @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
